// File: rtl/weight_col_feeder.sv
// rtl/weight_col_feeder.sv - north-edge weight source for one systolic-array column
// Optional feature macro: WEIGHT_FEEDER_COUNT_CHECK_EN (per-tile entry count check on tile_err).
module weight_col_feeder #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_IN        = 8,
    parameter int FIFO_DEPTH           = 4,
    localparam int IW = (SYSTOLIC_ARRAY_WIDTH > 1) ? $clog2(SYSTOLIC_ARRAY_WIDTH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic signed [DATA_WIDTH_IN-1:0] s_weight,
    input  logic [IW-1:0]                   s_index,
    input  logic                            s_last,
    input  logic                            col_enabled,
    input  logic                            switch_ack,
    output logic                            wf_accept_w,
    output logic signed [DATA_WIDTH_IN-1:0] wf_weight,
    output logic [IW-1:0]                   wf_index,
    output logic                            load_done,
    output logic                            busy,
    output logic                            tile_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH_IN + IW + 1;
    localparam int CW = $clog2(SYSTOLIC_ARRAY_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_SW} state_t;

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic          r_ready_en;
    state_t        r_state;
    logic [CW-1:0] r_drain_cnt;
    logic          r_accept;
    logic signed [DATA_WIDTH_IN-1:0] r_weight;
    logic [IW-1:0] r_index;
    logic          r_load_done;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;
    logic          w_head_last;

    assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign s_ready     = r_ready_en && !w_full;
    assign w_push      = s_valid && s_ready;
    assign w_pop       = ((r_state == IDLE) || (r_state == STREAM)) && !w_empty && col_enabled;
    assign w_head      = r_mem[r_rd_ptr[PW-1:0]];
    assign w_head_last = w_head[0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= {s_weight, s_index, s_last};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ready_en  <= 1'b0;
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_accept    <= 1'b0;
            r_weight    <= '0;
            r_index     <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_ready_en  <= 1'b1;
            r_load_done <= 1'b0;
            r_accept    <= w_pop;
            r_weight    <= w_pop ? $signed(w_head[EW-1 -: DATA_WIDTH_IN]) : '0;
            r_index     <= w_pop ? w_head[IW:1] : '0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case (r_state)
                IDLE, STREAM: begin
                    // Counter is loaded so it reads full width while the last entry is on wf_*
                    if (w_pop) begin
                        if (w_head_last) begin
                            r_state     <= DRAIN;
                            r_drain_cnt <= CW'(SYSTOLIC_ARRAY_WIDTH);
                        end else begin
                            r_state <= STREAM;
                        end
                    end
                end
                DRAIN: begin
                    // Stay in DRAIN during the load_done cycle so a same-cycle switch_ack is ignored
                    if (r_drain_cnt == '0) begin
                        r_state <= WAIT_SW;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                        r_load_done <= (r_drain_cnt == CW'(1));
                    end
                end
                WAIT_SW: begin
                    if (switch_ack && col_enabled) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wf_accept_w = r_accept;
    assign wf_weight   = r_weight;
    assign wf_index    = r_index;
    assign load_done   = r_load_done;
    assign busy        = (r_state != IDLE);

`ifdef WEIGHT_FEEDER_COUNT_CHECK_EN
    logic [CW:0] r_issue_cnt;
    logic        r_tile_err;
    logic [CW:0] w_cnt_next;

    assign w_cnt_next = (r_issue_cnt == '1) ? r_issue_cnt : r_issue_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
            r_tile_err  <= 1'b0;
        end else begin
            r_tile_err <= 1'b0;
            if (w_pop) begin
                if (w_head_last) begin
                    r_tile_err  <= (w_cnt_next != (CW+1)'(SYSTOLIC_ARRAY_WIDTH));
                    r_issue_cnt <= '0;
                end else begin
                    r_issue_cnt <= w_cnt_next;
                end
            end
        end
    end

    assign tile_err = r_tile_err;
`else
    assign tile_err = 1'b0;
`endif
endmodule

// File: tb/tb_weight_col_feeder.sv
// tb/tb_weight_col_feeder.sv - scoreboard bench for weight_col_feeder
module tb_weight_col_feeder;
    typedef struct {
        logic [7:0] w;
        logic [3:0] idx;
        logic       last;
        int         pcyc;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_weight = '0;
    logic [3:0] s_index = '0;
    logic       s_last = 1'b0;
    logic       col_enabled = 1'b0;
    logic       switch_ack = 1'b0;
    logic       wf_accept_w;
    logic [7:0] wf_weight;
    logic [3:0] wf_index;
    logic       load_done;
    logic       busy;
    logic       tile_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 0;
    bit   rand_gap = 0;
    bit   blocked = 0;
    bit   ld_seen = 0;
    bit   prev_can = 0;
    int   exp_ld = -1;
    int   unblock_at = -1;
    int   tile_cnt = 0;
    int   tiles_done = 0;
    ent_t q[$];
    ent_t send_q[$];

    weight_col_feeder #(
        .SYSTOLIC_ARRAY_WIDTH(16),
        .DATA_WIDTH_IN(8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_weight(s_weight),
        .s_index(s_index), .s_last(s_last),
        .col_enabled(col_enabled), .switch_ack(switch_ack),
        .wf_accept_w(wf_accept_w), .wf_weight(wf_weight), .wf_index(wf_index),
        .load_done(load_done), .busy(busy), .tile_err(tile_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream driver: presents queued entries, holding each until accepted
    initial begin
        bit   fire;
        ent_t e;
        forever begin
            @(negedge clk);
            fire = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_valid = 1'b0;
                send_q.delete();
            end else begin
                if (fire) s_valid = 1'b0;
                if (!s_valid && send_q.size() > 0 && !(rand_gap && $urandom_range(0, 3) == 0)) begin
                    e        = send_q.pop_front();
                    s_valid  = 1'b1;
                    s_weight = e.w;
                    s_index  = e.idx;
                    s_last   = e.last;
                end
            end
        end
    end

    // Monitor / reference model: FIFO contents as a queue, tile phase as a blocked flag
    initial begin
        int   c;
        bit   exp_acc;
        bit   exp_err;
        bit   can_now;
        ent_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                q.delete();
                blocked = 0; ld_seen = 0; prev_can = 0;
                exp_ld = -1; unblock_at = -1; tile_cnt = 0;
            end else begin
                c = cyc;
                if (c == unblock_at) begin
                    blocked = 0;
                    unblock_at = -1;
                    tiles_done++;
                    chk("busy_idle_after_switch", 32'(busy), 32'(0));
                end
                exp_acc = prev_can && q.size() > 0 && q[0].pcyc <= c - 2;
                chk("accept_w", 32'(wf_accept_w), 32'(exp_acc));
                exp_err = 0;
                if (wf_accept_w) begin
                    if (q.size() == 0) begin
                        chk("issue_without_entry", 32'(1), 32'(0));
                    end else begin
                        e = q.pop_front();
                        chk("weight", 32'(wf_weight), 32'(e.w));
                        chk("index", 32'(wf_index), 32'(e.idx));
                        chk("busy_on_issue", 32'(busy), 32'(1));
                        tile_cnt++;
                        if (e.last) begin
`ifdef WEIGHT_FEEDER_COUNT_CHECK_EN
                            exp_err = (tile_cnt != 16);
`endif
                            tile_cnt = 0;
                            blocked  = 1;
                            ld_seen  = 0;
                            exp_ld   = c + 16;
                        end
                    end
                end else if (wf_weight != 0 || wf_index != 0) begin
                    chk("bubble_zero", {wf_weight, wf_index}, 32'(0));
                end
                chk("tile_err", 32'(tile_err), 32'(exp_err));
                if (blocked) chk("busy_in_tile", 32'(busy), 32'(1));
                if (load_done || c == exp_ld)
                    chk("load_done_time", 32'(load_done), 32'(c == exp_ld));
                if (blocked && ld_seen && switch_ack && col_enabled && unblock_at < 0)
                    unblock_at = c + 1;
                if (load_done && blocked) ld_seen = 1;
                can_now  = !blocked && col_enabled;
                prev_can = can_now;
                chk("s_ready", 32'(s_ready), 32'(q.size() < 4));
                if (s_valid && s_ready) begin
                    e.w = s_weight; e.idx = s_index; e.last = s_last; e.pcyc = c;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_accept_w", 32'(wf_accept_w), 32'(0));
        chk("rst_wf_data", {wf_weight, wf_index}, 32'(0));
        chk("rst_load_done", 32'(load_done), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_s_ready", 32'(s_ready), 32'(0));
        chk("rst_tile_err", 32'(tile_err), 32'(0));
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_s_ready", 32'(s_ready), 32'(1));
        mon_en = 1;
    endtask

    task automatic send_tile(input int n, input bit directed);
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e.w    = directed ? 8'(i - 8) : 8'($urandom);
            e.idx  = directed ? 4'(i) : 4'($urandom_range(0, 15));
            e.last = (i == n - 1);
            e.pcyc = 0;
            send_q.push_back(e);
        end
    endtask

    task automatic wait_ld();
        bit seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (load_done) seen = 1;
        end
        if (!seen) chk("load_done_timeout", 32'(0), 32'(1));
    endtask

    task automatic ack_after(input int k);
        repeat (k) @(posedge clk);
        #1 switch_ack = 1'b1;
        @(posedge clk);
        #1 switch_ack = 1'b0;
    endtask

    initial begin
        int target;
        int k;
        do_reset();
        @(posedge clk); #1 col_enabled = 1'b1;

        send_tile(16, 1);
        wait_ld();
        ack_after(3);

        @(posedge clk); #1 col_enabled = 1'b0;
        send_tile(6, 1);
        repeat (10) @(posedge clk);
        #1 col_enabled = 1'b1;
        wait_ld();
        ack_after(1);

        send_tile(16, 1);
        send_tile(16, 0);
        wait_ld();
        ack_after(3);
        wait_ld();
        ack_after(2);

        send_tile(16, 1);
        repeat (5) @(posedge clk);
        #1 col_enabled = 1'b0;
        repeat (5) @(posedge clk);
        #1 col_enabled = 1'b1;
        wait_ld();
        ack_after(1);

        send_tile(16, 0);
        k = 0;
        while (!blocked && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!blocked) chk("drain_reach_timeout", 32'(0), 32'(1));
        repeat (4) @(posedge clk);
        do_reset();
        @(posedge clk); #1 col_enabled = 1'b1;
        send_tile(16, 1);
        wait_ld();
        ack_after(1);

        send_tile(10, 1);
        wait_ld();
        ack_after(1);
        send_tile(16, 0);
        wait_ld();
        ack_after(1);

        rand_gap = 1;
        target = tiles_done + 8;
        for (int t = 0; t < 8; t++) send_tile($urandom_range(1, 20), 0);
        k = 0;
        while (tiles_done < target && k < 4000) begin
            @(posedge clk);
            #1;
            col_enabled = ($urandom_range(0, 3) != 0);
            switch_ack  = col_enabled && ($urandom_range(0, 2) == 0);
            k++;
        end
        if (tiles_done < target) chk("random_tiles_timeout", 32'(tiles_done), 32'(target));
        #1;
        switch_ack  = 1'b0;
        col_enabled = 1'b1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/weight_col_feeder.md
Name: weight_col_feeder

Overview:
- Per-column weight source at the north edge of the systolic array. Drives one column's top PE weight bus: accept_w, weight and index.
- Buffers incoming weight entries for one tile of up to SYSTOLIC_ARRAY_WIDTH rows. Streams them down the column, where each PE takes the entry whose index matches its row.
- Signals when the tile has fully settled in the inactive registers. Blocks the next tile until the controller confirms the active/inactive switch.

Parameters:
- SYSTOLIC_ARRAY_WIDTH, 16, array rows; sets index width clog2(SYSTOLIC_ARRAY_WIDTH) and drain length.
- DATA_WIDTH_IN, 8, signed weight width.
- FIFO_DEPTH, 4, entry buffer depth; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream entry valid.
- s_ready  out  1  feeder can accept an entry.
- s_weight  in  DATA_WIDTH_IN  signed weight.
- s_index  in  clog2(SYSTOLIC_ARRAY_WIDTH)  target row.
- s_last  in  1  final entry of the tile.
- col_enabled  in  1  column enable; same signal the column's PEs see.
- switch_ack  in  1  controller has issued the switch for this column.
- wf_accept_w  out  1  to top PE accept_w input.
- wf_weight  out  DATA_WIDTH_IN  to top PE weight input.
- wf_index  out  clog2(SYSTOLIC_ARRAY_WIDTH)  to top PE index input.
- load_done  out  1  one-cycle pulse: tile settled.
- busy  out  1  state != IDLE.
- tile_err  out  1  count-check pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values (async on rst_n low):
  - All outputs 0; s_ready goes 1 after reset release.
  - FIFO pointers cleared, state IDLE, counters 0.
  - Reset mid-tile discards all buffered entries; wf_accept_w drops to 0 immediately.
- Upstream handshake:
  - Push when s_valid && s_ready. FIFO stores {weight, index, last}.
  - s_ready = !full, registered-free. A pop in the same cycle does not raise s_ready.
  - Pushes are accepted in every state, including DRAIN and WAIT_SW.
- Issue rule: pop when state is IDLE or STREAM, FIFO non-empty and col_enabled=1.
  - Pop cycle t: wf_accept_w=1, with wf_weight/wf_index = entry, registered, visible at t+1.
  - Non-pop cycle: wf_accept_w=0, wf_weight=0, wf_index=0. Bubbles are legal.
- FSM:
  - IDLE: pop -> STREAM. If the popped entry has last=1 -> DRAIN directly.
  - STREAM: pop of entry with last=1 -> DRAIN. FIFO empty -> stay (bubble).
  - DRAIN:
    - drain_cnt loads SYSTOLIC_ARRAY_WIDTH on the cycle the last entry is driven on wf_accept_w, and decrements every cycle regardless of col_enabled.
    - At 0: load_done=1 for one cycle -> WAIT_SW.
    - No pops in DRAIN.
  - WAIT_SW: no pops. switch_ack=1 -> IDLE next cycle.
    - switch_ack in any other state is ignored.
    - switch_ack in the same cycle as load_done is ignored; it must arrive at load_done+1 or later.
- col_enabled=0: issue stalls, FIFO is held, FSM is held except the DRAIN countdown.
- Entry with index >= SYSTOLIC_ARRAY_WIDTH (non-power-of-two width only) is issued unchanged. No PE latches it; no error is raised.
- Single-entry tile (first entry has last=1) is legal.
- Latency: entry pushed into an empty FIFO in IDLE reaches wf_* 2 cycles later (push cycle, then pop cycle, then register).

Optional Feature:
- Macro WEIGHT_FEEDER_COUNT_CHECK_EN.
- Defined:
  - Per-tile counter of issued entries.
  - On issuing last, if count != SYSTOLIC_ARRAY_WIDTH, tile_err pulses 1 cycle (same cycle as that wf_accept_w).
  - Tile still completes normally. Counter clears on entry to DRAIN.
- Undefined: no counter; tile_err tied 0.

Test Plan:
- Reset then push 16 entries (index 0..15, weight = index-8, last on 15) with col_enabled=1 -> wf_accept_w high 16 consecutive cycles with matching weight/index; load_done pulses exactly 16 cycles after the last entry appears; busy=1 throughout.
- Hold s_valid with no pops (col_enabled=0) -> s_ready drops after 4 pushes, no wf_accept_w. Raise col_enabled -> pops resume one per cycle, s_ready returns the cycle after the first pop.
- Push tile A (last on entry 15) followed immediately by tile B entries -> no tile-B issue until switch_ack. Assert switch_ack 3 cycles after load_done -> first tile-B entry on wf_* 2 cycles after switch_ack.
- Deassert col_enabled for 5 cycles mid-STREAM -> wf_accept_w=0 and FIFO contents kept; order preserved after re-enable; index sequence unbroken.
- Assert rst_n low during DRAIN -> all outputs 0 asynchronously; after release, busy=0 and a fresh tile streams correctly.
- With WEIGHT_FEEDER_COUNT_CHECK_EN: tile of 10 entries -> tile_err pulses once with the 10th entry, load_done still pulses. Tile of 16 -> tile_err stays 0.
